// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 word mux toward a valid/ready sink.
// Each grant is capped at MAX_BURST accepted words, then one idle cycle.
module mux4_rr_arbiter #(
    parameter int W         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic         out_ready,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic [W-1:0] od,
    output logic         od_valid,
    output logic         busy
);

    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    gnt_nx;
    logic [1:0]    sel_nx;
    logic [1:0]    ptr, ptr_nx;
    logic [1:0]    pick;
    logic          found;
    logic [CW-1:0] count, count_nx;
    logic          xfer;
    logic          last_beat;
    logic [W-1:0]  mux;

    // Search starts just after the last released source.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && req[ptr + 2'(i)]) begin
                pick  = ptr + 2'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        unique case (sel)
            2'd0:    mux = d0;
            2'd1:    mux = d1;
            2'd2:    mux = d2;
            default: mux = d3;
        endcase
    end

    assign busy      = (state == GRANT);
    assign od_valid  = busy && req[sel];
    assign od        = od_valid ? mux : '0;
    assign xfer      = od_valid && out_ready;
    assign last_beat = (count == CW'(MAX_BURST - 1));

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        sel_nx   = sel;
        ptr_nx   = ptr;
        count_nx = count;
        unique case (state)
            IDLE: begin
                gnt_nx = 4'b0000;
                if (found) begin
                    state_nx = GRANT;
                    gnt_nx   = 4'b0001 << pick;
                    sel_nx   = pick;
                    count_nx = '0;
                end
            end
            default: begin
                if (!req[sel] || (xfer && last_beat)) begin
                    state_nx = IDLE;
                    gnt_nx   = 4'b0000;
                    ptr_nx   = sel;
                    count_nx = '0;
                end else if (xfer) begin
                    count_nx = count + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            ptr   <= 2'd3;
            count <= '0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            sel   <= sel_nx;
            ptr   <= ptr_nx;
            count <= count_nx;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: MAX_BURST=4 and MAX_BURST=1 instances on shared
// inputs, each tracked by an owner/beats/last-released model.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] d [4];
    logic       out_ready = 1'b0;

    logic [3:0] gnt_o [2];
    logic [1:0] sel_o [2];
    logic [3:0] od_o [2];
    logic       odv_o [2];
    logic       busy_o [2];

    int errors = 0;
    int checks = 0;
    bit run = 1'b0;

    int owner [2];
    int beats [2];
    int last [2];
    int msel [2];

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.W(4), .MAX_BURST(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .out_ready(out_ready),
        .gnt(gnt_o[0]), .sel(sel_o[0]), .od(od_o[0]),
        .od_valid(odv_o[0]), .busy(busy_o[0])
    );

    mux4_rr_arbiter #(.W(4), .MAX_BURST(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .out_ready(out_ready),
        .gnt(gnt_o[1]), .sel(sel_o[1]), .od(od_o[1]),
        .od_valid(odv_o[1]), .busy(busy_o[1])
    );

    function automatic int limit(input int m);
        return (m == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: who owns the path, how many words it has moved, who went last.
    always @(posedge clk or negedge rst_n) begin
        for (int m = 0; m < 2; m++) begin
            int o, b, l, s;
            o = owner[m]; b = beats[m]; l = last[m]; s = msel[m];
            if (!rst_n) begin
                o = -1; b = 0; l = 3; s = 0;
            end else if (o < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (o < 0 && req[(l + k) % 4]) begin
                        o = (l + k) % 4; s = o; b = 0;
                    end
                end
            end else if (!req[o]) begin
                l = o; o = -1; b = 0;
            end else if (out_ready) begin
                b = b + 1;
                if (b == limit(m)) begin
                    l = o; o = -1; b = 0;
                end
            end
            owner[m] <= o; beats[m] <= b; last[m] <= l; msel[m] <= s;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            for (int m = 0; m < 2; m++) begin
                logic [3:0] eg;
                logic ev;
                eg = (owner[m] >= 0) ? (4'b0001 << owner[m]) : 4'b0000;
                ev = (owner[m] >= 0) && req[owner[m]];
                chk($sformatf("m%0d_gnt", m), 32'(gnt_o[m]), 32'(eg));
                chk($sformatf("m%0d_sel", m), 32'(sel_o[m]), 32'(msel[m]));
                chk($sformatf("m%0d_vld", m), 32'(odv_o[m]), 32'(ev));
                chk($sformatf("m%0d_od", m), 32'(od_o[m]),
                    32'(ev ? d[owner[m]] : 4'h0));
                chk($sformatf("m%0d_busy", m), 32'(busy_o[m]),
                    32'(owner[m] >= 0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    int seq [$];
    int expo [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int i = 0; i < 4; i++) d[i] = 4'(i + 1);
        #1;
        step();
        run = 1'b1;
        at_neg();
        chk("rst_gnt", 32'(gnt_o[0]), 32'h0);
        chk("rst_vld", 32'(odv_o[0]), 32'h0);
        chk("rst_od", 32'(od_o[0]), 32'h0);
        chk("rst_sel", 32'(sel_o[0]), 32'h0);

        // Single requester 2: four beats, one idle cycle, re-grant.
        do_reset();
        req = 4'b0100; d[2] = 4'hA;
        step();
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("t1_gnt", 32'(gnt_o[0]), 32'h4);
            chk("t1_sel", 32'(sel_o[0]), 32'h2);
            chk("t1_od", 32'(od_o[0]), 32'hA);
            step();
        end
        at_neg();
        chk("t1_gap", 32'(gnt_o[0]), 32'h0);
        step();
        at_neg();
        chk("t1_regnt", 32'(gnt_o[0]), 32'h4);

        // All requesting: rotation order.
        do_reset();
        req = 4'b1111;
        begin
            logic [3:0] prev;
            prev = 4'b0000;
            for (int c = 0; c < 30; c++) begin
                at_neg();
                if (prev == 4'b0000 && gnt_o[0] != 4'b0000)
                    for (int b = 0; b < 4; b++)
                        if (gnt_o[0][b]) seq.push_back(b);
                prev = gnt_o[0];
                step();
            end
        end
        chk("t2_ngrants", 32'(seq.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < seq.size(); i++)
            chk($sformatf("t2_order%0d", i), 32'(seq[i]), 32'(expo[i]));

        // Backpressure on source 1 after two transfers.
        do_reset();
        req = 4'b0010; d[1] = 4'h5;
        step();
        step();
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            chk("t3_stall_vld", 32'(odv_o[0]), 32'h1);
            chk("t3_stall_od", 32'(od_o[0]), 32'h5);
            step();
        end
        out_ready = 1'b1;
        step();
        at_neg();
        chk("t3_still", 32'(gnt_o[0]), 32'h2);
        step();
        at_neg();
        chk("t3_rel", 32'(gnt_o[0]), 32'h0);

        // Source 3 drops request after one transfer.
        do_reset();
        req = 4'b1000;
        step();
        at_neg();
        chk("t4_gnt3", 32'(gnt_o[0]), 32'h8);
        step();
        req = 4'b0001;
        step();
        at_neg();
        chk("t4_rel", 32'(gnt_o[0]), 32'h0);
        step();
        at_neg();
        chk("t4_gnt0", 32'(gnt_o[0]), 32'h1);

        // Asynchronous reset mid-burst.
        do_reset();
        req = 4'b0100;
        step();
        step();
        step();
        at_neg();
        rst_n = 1'b0;
        #1;
        chk("t5_gnt", 32'(gnt_o[0]), 32'h0);
        chk("t5_vld", 32'(odv_o[0]), 32'h0);
        chk("t5_od", 32'(od_o[0]), 32'h0);
        chk("t5_busy", 32'(busy_o[0]), 32'h0);
        req = 4'b1111;
        step();
        rst_n = 1'b1;
        step();
        at_neg();
        chk("t5_first", 32'(gnt_o[0]), 32'h1);
        chk("t5_first_b1", 32'(gnt_o[1]), 32'h1);

        // Last beat followed by request drop.
        do_reset();
        req = 4'b0100;
        repeat (4) step();
        step();
        req = 4'b0000;
        at_neg();
        chk("t6_gap", 32'(gnt_o[0]), 32'h0);
        step();
        at_neg();
        chk("t6_none", 32'(gnt_o[0]), 32'h0);

        // Random traffic with sticky requests.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            if (!(odv_o[0] && !out_ready))
                for (int i = 0; i < 4; i++) d[i] = 4'($urandom);
            step();
        end

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter sharing one 4:1 word multiplexer (4 data sources, 2-bit select) between four requesters.
- Grants one requester at a time and drives the mux select.
- Presents the selected word downstream with a valid/ready handshake.
- Caps each grant at a burst limit so no requester can hold the shared path indefinitely.

Parameters:
- W, 4, data word width per source and on od.
- MAX_BURST, 4, max accepted transfers per grant (>=1); counter width = clog2(MAX_BURST)+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per source; bit i belongs to di.
- d0  input  W  source 0 data.
- d1  input  W  source 1 data.
- d2  input  W  source 2 data.
- d3  input  W  source 3 data.
- out_ready  input  1  downstream accepts od this cycle.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  mux select of current/last grant, registered.
- od  output  W  selected word; 0 when od_valid=0.
- od_valid  output  1  od holds a valid word.
- busy  output  1  state==GRANT.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE, gnt=0, sel=0, od_valid=0, od=0, busy=0, burst count=0, priority pointer ptr=3, so source 0 has first priority.
- FSM IDLE:
  - If req!=0, pick the first set bit in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Register gnt=onehot(pick) and sel=pick, clear count, go to GRANT.
  - If req==0, stay in IDLE with gnt=0.
  - Latency: req sampled at edge N gives gnt/sel visible after edge N+1. Grant decision uses req only; data is not examined.
- FSM GRANT:
  - od_valid = req[sel] (combinational, gated by state).
  - od = mux(d0..d3, sel) when od_valid, else 0. The mux path is combinational; d must be stable while od_valid && !out_ready.
  - Transfer = od_valid && out_ready. Each transfer increments count.
- Release from GRANT to IDLE at the edge where either:
  - (a) a transfer occurs with count==MAX_BURST-1, or
  - (b) req[sel]==0.
- On release:
  - gnt<=0, ptr<=sel, count<=0.
  - sel keeps its last value; busy drops.
  - One mandatory IDLE cycle occurs between grants, so back-to-back grants are spaced by at least 1 cycle with gnt=0.
- Backpressure: out_ready=0 holds state, count, gnt and sel. There is no timeout, so a requester holding req under sustained backpressure keeps the grant.
- Simultaneous events: last-burst transfer in the same cycle that req[sel] drops is a single release (count 0, ptr=sel). req changes on non-granted bits during GRANT have no effect until IDLE.
- Fairness: after releasing source k, source k has lowest priority at the next arbitration. With all req high, grants cycle 0,1,2,3,0,...
- MAX_BURST=1: every accepted transfer releases the grant.
- Reset mid-burst: immediate return to reset values regardless of state or handshake; the in-flight word is dropped. After reset, source 0 has priority again.
- No X on outputs after reset. gnt is always 0 or one-hot. sel changes only on the IDLE->GRANT edge.

Test Plan:
- Reset then req=4'b0100, d2=4'hA, out_ready=1: gnt=4'b0100 and sel=2 one cycle after req sampled; od=4'hA, od_valid=1 for 4 cycles; then gnt=0 for 1 cycle and re-grant to source 2.
- All req=4'b1111 held, out_ready=1, MAX_BURST=4: grant order 0,1,2,3,0, each 4 transfers, each grant separated by exactly 1 IDLE cycle; gnt always one-hot.
- Source 1 granted, out_ready low 3 cycles after 2 transfers: od_valid=1, od stable, count stays 2; after out_ready returns, exactly 2 more transfers, then release.
- Source 3 granted, req[3] drops after 1 transfer: release at that edge, ptr=3; pending req=4'b1001 next grants source 0.
- rst_n pulsed low mid-burst (source 2, count=2): gnt=0, od_valid=0, od=0 asynchronously; with req=4'b1111 after reset, first grant goes to source 0.
- Directed last-beat plus req drop in the same cycle, and a MAX_BURST=1 build: single release each time, no extra grant cycle, no transfer counted twice.
